// File: rtl/sync_register_file_if.sv
// Bus bundle for sync_register_file: chip select, clear, write port, two read ports.
// Parity pins exist only when REGFILE_PARITY_EN is defined.
interface sync_register_file_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5
);
    logic             cs_ni;
    logic             clear_i;
    logic             busy_o;
    logic             we_i;
    logic [DEPTH-1:0] waddr_i;
    logic [WIDTH-1:0] wdata_i;
    logic             re_a_i;
    logic [DEPTH-1:0] raddr_a_i;
    logic [WIDTH-1:0] rdata_a_o;
    logic             rvalid_a_o;
    logic             re_b_i;
    logic [DEPTH-1:0] raddr_b_i;
    logic [WIDTH-1:0] rdata_b_o;
    logic             rvalid_b_o;
`ifdef REGFILE_PARITY_EN
    logic             perr_inj_i;
    logic             perr_a_o;
    logic             perr_b_o;
`endif

    modport master (
`ifdef REGFILE_PARITY_EN
        output perr_inj_i,
        input  perr_a_o, perr_b_o,
`endif
        output cs_ni, clear_i, we_i, waddr_i, wdata_i,
        output re_a_i, raddr_a_i, re_b_i, raddr_b_i,
        input  busy_o, rdata_a_o, rvalid_a_o, rdata_b_o, rvalid_b_o
    );

    modport slave (
`ifdef REGFILE_PARITY_EN
        input  perr_inj_i,
        output perr_a_o, perr_b_o,
`endif
        input  cs_ni, clear_i, we_i, waddr_i, wdata_i,
        input  re_a_i, raddr_a_i, re_b_i, raddr_b_i,
        output busy_o, rdata_a_o, rvalid_a_o, rdata_b_o, rvalid_b_o
    );
endinterface

// File: rtl/sync_register_file.sv
// 1-write / 2-read synchronous register file with a built-in clear sweep.
// Define REGFILE_PARITY_EN to store and check an even-parity bit per entry.
module sync_register_file #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 5,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input logic                 clk_i,
    input logic                 rst_i,
    sync_register_file_if.slave bus
);
`ifdef REGFILE_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif
    localparam int N = 2 ** DEPTH;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

    state_e           state_q, state_d;
    logic [DEPTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
    logic             rvalid_a_q, rvalid_a_d;
    logic             rvalid_b_q, rvalid_b_d;
    logic             perr_a_q, perr_a_d;
    logic             perr_b_q, perr_b_d;

    logic [MW-1:0]    mem [N];
    logic             mem_we;
    logic [DEPTH-1:0] mem_waddr;
    logic [MW-1:0]    mem_wdata;

    logic             idle, wr_acc, rd_a_acc, rd_b_acc;
    logic [MW-1:0]    wword, cword, word_a, word_b;

    always_comb begin
        idle     = (state_q == ST_IDLE);
        wr_acc   = idle && !bus.cs_ni && bus.we_i;
        rd_a_acc = idle && !bus.cs_ni && bus.re_a_i;
        rd_b_acc = idle && !bus.cs_ni && bus.re_b_i;
`ifdef REGFILE_PARITY_EN
        wword = {(^bus.wdata_i) ^ bus.perr_inj_i, bus.wdata_i};
        cword = {^CLEAR_VALUE, CLEAR_VALUE};
`else
        wword = bus.wdata_i;
        cword = CLEAR_VALUE;
`endif

        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = bus.waddr_i;
        mem_wdata = wword;
        unique case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = cword;
                cnt_d     = cnt_q + 1'b1;
                if (&cnt_q) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                mem_we = wr_acc;
                if (bus.clear_i && !bus.cs_ni) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase

        // write-first: a same-cycle write to the read address is forwarded
        word_a = (wr_acc && bus.waddr_i == bus.raddr_a_i)
               ? wword : mem[bus.raddr_a_i];
        word_b = (wr_acc && bus.waddr_i == bus.raddr_b_i)
               ? wword : mem[bus.raddr_b_i];

        rdata_a_d  = rd_a_acc ? word_a[WIDTH-1:0] : rdata_a_q;
        rdata_b_d  = rd_b_acc ? word_b[WIDTH-1:0] : rdata_b_q;
        rvalid_a_d = rd_a_acc;
        rvalid_b_d = rd_b_acc;
        perr_a_d   = rd_a_acc && (^word_a) && (MW > WIDTH);
        perr_b_d   = rd_b_acc && (^word_b) && (MW > WIDTH);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            perr_a_q   <= 1'b0;
            perr_b_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            perr_a_q   <= perr_a_d;
            perr_b_q   <= perr_b_d;
        end
    end

    // array has no reset so it stays RAM-inferable
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign bus.busy_o     = (state_q == ST_CLEAR);
    assign bus.rdata_a_o  = rdata_a_q;
    assign bus.rdata_b_o  = rdata_b_q;
    assign bus.rvalid_a_o = rvalid_a_q;
    assign bus.rvalid_b_o = rvalid_b_q;
`ifdef REGFILE_PARITY_EN
    assign bus.perr_a_o   = perr_a_q;
    assign bus.perr_b_o   = perr_b_q;
`else
    logic unused_perr;
    assign unused_perr = perr_a_q ^ perr_b_q;
`endif
endmodule

// File: tb/tb_sync_register_file.sv
// Self-checking bench for sync_register_file: directed steps plus random
// traffic against an array-based reference model.
module tb_sync_register_file;
    localparam int W = 8;
    localparam int D = 5;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sync_register_file_if #(.WIDTH(W), .DEPTH(D)) bus ();

    sync_register_file #(.WIDTH(W), .DEPTH(D), .CLEAR_VALUE(8'h00)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] ref_mem [N];
    bit           ref_bad [N];
    int           clear_left;
    logic [W-1:0] exp_a, exp_b;
    bit           exp_va, exp_vb, exp_pa, exp_pb;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("busy", 32'(bus.busy_o), 32'(clear_left > 0));
        chk("rvalid_a", 32'(bus.rvalid_a_o), 32'(exp_va));
        chk("rvalid_b", 32'(bus.rvalid_b_o), 32'(exp_vb));
        chk("rdata_a", 32'(bus.rdata_a_o), 32'(exp_a));
        chk("rdata_b", 32'(bus.rdata_b_o), 32'(exp_b));
`ifdef REGFILE_PARITY_EN
        chk("perr_a", 32'(bus.perr_a_o), 32'(exp_pa));
        chk("perr_b", 32'(bus.perr_b_o), 32'(exp_pb));
`endif
    endtask

    task automatic model_reset();
        clear_left = N;
        exp_a = '0; exp_b = '0;
        exp_va = 0; exp_vb = 0; exp_pa = 0; exp_pb = 0;
        for (int i = 0; i < N; i++) begin
            ref_mem[i] = '0;
            ref_bad[i] = 0;
        end
    endtask

    // advance the model by one clock using current inputs, then check
    task automatic step();
        bit sel, inj;
        sel = !bus.cs_ni;
        inj = 0;
`ifdef REGFILE_PARITY_EN
        inj = bus.perr_inj_i;
`endif
        if (rst) begin
            model_reset();
        end else if (clear_left > 0) begin
            clear_left--;
            exp_va = 0; exp_vb = 0; exp_pa = 0; exp_pb = 0;
        end else begin
            exp_va = sel && bus.re_a_i;
            exp_vb = sel && bus.re_b_i;
            exp_pa = 0; exp_pb = 0;
            if (exp_va) begin
                if (sel && bus.we_i && bus.waddr_i == bus.raddr_a_i) begin
                    exp_a = bus.wdata_i; exp_pa = inj;
                end else begin
                    exp_a = ref_mem[bus.raddr_a_i];
                    exp_pa = ref_bad[bus.raddr_a_i];
                end
            end
            if (exp_vb) begin
                if (sel && bus.we_i && bus.waddr_i == bus.raddr_b_i) begin
                    exp_b = bus.wdata_i; exp_pb = inj;
                end else begin
                    exp_b = ref_mem[bus.raddr_b_i];
                    exp_pb = ref_bad[bus.raddr_b_i];
                end
            end
            if (sel && bus.we_i) begin
                ref_mem[bus.waddr_i] = bus.wdata_i;
                ref_bad[bus.waddr_i] = inj;
            end
            if (sel && bus.clear_i) begin
                clear_left = N;
                for (int i = 0; i < N; i++) begin
                    ref_mem[i] = '0;
                    ref_bad[i] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_in();
        bus.cs_ni = 1'b0; bus.clear_i = 1'b0; bus.we_i = 1'b0;
        bus.re_a_i = 1'b0; bus.re_b_i = 1'b0;
`ifdef REGFILE_PARITY_EN
        bus.perr_inj_i = 1'b0;
`endif
    endtask

    task automatic wait_idle(input string tag, input int want);
        int n;
        n = 0;
        while (bus.busy_o && n < 100) begin
            step();
            n++;
        end
        chk(tag, 32'(n), 32'(want));
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < N; i++) begin
            bus.re_a_i = 1'b1; bus.raddr_a_i = 5'(i);
            bus.re_b_i = 1'b1; bus.raddr_b_i = 5'(N - 1 - i);
            step();
        end
        idle_in();
        chk(tag, 32'(bus.rdata_a_o), 32'(exp_a));
    endtask

    initial begin
        idle_in();
        bus.waddr_i = '0; bus.wdata_i = '0;
        bus.raddr_a_i = '0; bus.raddr_b_i = '0;
        #2 rst = 1'b1;
        model_reset();
        #1 check_outputs();
        step();
        rst = 1'b0;
        wait_idle("busy_len_reset", N);
        read_all("zero_read");

        // fill with address pattern, then cross-read
        for (int i = 0; i < N; i++) begin
            bus.we_i = 1'b1; bus.waddr_i = 5'(i); bus.wdata_i = 8'(i);
            step();
        end
        idle_in();
        for (int i = 0; i < N; i++) begin
            bus.re_a_i = 1'b1; bus.raddr_a_i = 5'(i);
            bus.re_b_i = 1'b1; bus.raddr_b_i = 5'(N - 1 - i);
            step();
            chk("fill_a", 32'(bus.rdata_a_o), 32'(i));
            chk("fill_b", 32'(bus.rdata_b_o), 32'(N - 1 - i));
        end
        idle_in();

        // B reads old value of 7, then A reads 7 during its write
        bus.re_b_i = 1'b1; bus.raddr_b_i = 5'd7;
        step();
        chk("old_b7", 32'(bus.rdata_b_o), 32'h7);
        idle_in();
        bus.we_i = 1'b1; bus.waddr_i = 5'd7; bus.wdata_i = 8'hA5;
        bus.re_a_i = 1'b1; bus.raddr_a_i = 5'd7;
        step();
        chk("bypass_a7", 32'(bus.rdata_a_o), 32'hA5);
        idle_in();

        // deselected write and reads are dropped
        bus.cs_ni = 1'b1; bus.we_i = 1'b1; bus.waddr_i = 5'd3;
        bus.wdata_i = 8'hFF; bus.re_a_i = 1'b1; bus.re_b_i = 1'b1;
        step();
        idle_in();
        bus.re_a_i = 1'b1; bus.raddr_a_i = 5'd3;
        step();
        chk("cs_hold3", 32'(bus.rdata_a_o), 32'h3);
        idle_in();

        // random traffic with occasional clear and deselect
        for (int k = 0; k < 400; k++) begin
            bus.cs_ni = ($urandom_range(0, 9) == 0);
            bus.clear_i = ($urandom_range(0, 59) == 0);
            bus.we_i = 1'($urandom_range(0, 1));
            bus.waddr_i = 5'($urandom_range(0, 7));
            bus.wdata_i = 8'($urandom);
            bus.re_a_i = 1'($urandom_range(0, 1));
            bus.raddr_a_i = 5'($urandom_range(0, 7));
            bus.re_b_i = 1'($urandom_range(0, 1));
            bus.raddr_b_i = 5'($urandom_range(0, 7));
`ifdef REGFILE_PARITY_EN
            bus.perr_inj_i = ($urandom_range(0, 3) == 0);
`endif
            step();
        end
        idle_in();
        wait_idle("rand_settle", clear_left);

        // fill, clear, reset mid-sweep at count 10, write lost in sweep
        for (int i = 0; i < N; i++) begin
            bus.we_i = 1'b1; bus.waddr_i = 5'(i); bus.wdata_i = 8'(i + 100);
            step();
        end
        idle_in();
        bus.clear_i = 1'b1;
        step();
        idle_in();
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        model_reset();
        #2 check_outputs();
        step();
        rst = 1'b0;
        bus.we_i = 1'b1; bus.waddr_i = 5'd5; bus.wdata_i = 8'h77;
        step();
        idle_in();
        wait_idle("busy_len_rst_mid", N - 1);
        read_all("cleared_read");

`ifdef REGFILE_PARITY_EN
        bus.we_i = 1'b1; bus.waddr_i = 5'd2; bus.wdata_i = 8'h0F;
        bus.perr_inj_i = 1'b1;
        step();
        bus.waddr_i = 5'd4; bus.perr_inj_i = 1'b0;
        step();
        idle_in();
        bus.re_a_i = 1'b1; bus.raddr_a_i = 5'd2;
        step();
        chk("perr_addr2", 32'(bus.perr_a_o), 32'h1);
        bus.raddr_a_i = 5'd4;
        step();
        chk("perr_addr4", 32'(bus.perr_a_o), 32'h0);
        idle_in();
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
